// File: rtl/mem_if.sv
// Cache-to-memory request/response bundle: the cache drives the request side
// (master), the memory model answers with data, ready and error (slave).
interface mem_if;
  logic [31:0] mem_req_addr;
  logic        mem_req_vaild;
  logic        mem_req_wr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_req_data;
  logic        mem_req_ready;
  logic        mem_err;

  modport master (
    output mem_req_addr, mem_req_vaild, mem_req_wr, mem_wr_data,
    input  mem_req_data, mem_req_ready, mem_err
  );

  modport slave (
    input  mem_req_addr, mem_req_vaild, mem_req_wr, mem_wr_data,
    output mem_req_data, mem_req_ready, mem_err
  );
endinterface

// File: rtl/mem_ctrl.sv
// Fixed-latency word-addressed main memory behind the instruction cache, with
// out-of-range flagging and saturating read/write access counters.
module mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem_if.slave        bus,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             wr_q, wr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [15:0]      rd_cnt_q, rd_cnt_d;
  logic [15:0]      wr_cnt_q, wr_cnt_d;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             enter_resp;
  logic [31:0]      acc_addr;
  logic             acc_wr;
  logic [31:0]      acc_wdata;
  logic             acc_in_range;
  logic [IDX_W-1:0] acc_idx;
  logic             mem_we;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_req_vaild) begin
          addr_d  = bus.mem_req_addr;
          wr_d    = bus.mem_req_wr;
          wdata_d = bus.mem_wr_data;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With single-cycle latency the access happens on the accepting edge, so the
  // operands come straight from the bus instead of the latched copy.
  always_comb begin
    acc_addr     = (state_q == IDLE) ? bus.mem_req_addr : addr_q;
    acc_wr       = (state_q == IDLE) ? bus.mem_req_wr   : wr_q;
    acc_wdata    = (state_q == IDLE) ? bus.mem_wr_data  : wdata_q;
    acc_in_range = (acc_addr[31:IDX_W+2] == '0);
    acc_idx      = acc_addr[IDX_W+1:2];
    mem_we       = enter_resp && acc_wr && acc_in_range;
    err_d        = enter_resp && !acc_in_range;
    rdata_d      = rdata_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    if (enter_resp) begin
      if (!acc_in_range) begin
        rdata_d = 32'h0;
      end else if (acc_wr) begin
        rdata_d  = acc_wdata;
        wr_cnt_d = sat_inc(wr_cnt_q);
      end else begin
        rdata_d  = mem_q[acc_idx];
        rd_cnt_d = sat_inc(rd_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rd_cnt_q <= 16'h0;
      wr_cnt_q <= 16'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Request payload and storage are not reset; a reset edge must still block
  // the array write so an aborted request leaves memory untouched.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
    if (rst && mem_we) mem_q[acc_idx] <= acc_wdata;
  end

  assign bus.mem_req_ready = (state_q == RESP);
  assign bus.mem_req_data  = rdata_q;
  assign bus.mem_err       = err_q;
  assign rd_count          = rd_cnt_q;
  assign wr_count          = wr_cnt_q;
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Word-addressed main-memory model with fixed, parameterised access latency, sitting directly downstream of the instruction cache. It serves one cache-side request at a time (line refill reads and write-backs) over the cache's memory valid/ready handshake. It also flags out-of-range accesses and keeps saturating read/write access counters for performance measurement.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 2.
- LATENCY, 4: cycles from request acceptance to the ready pulse; ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low (rst = 0 resets the block at the rising edge).
- mem_req_addr  in  32  byte address; bits [1:0] are ignored.
- mem_req_vaild  in  1  request valid, held by the cache until it sees ready.
- mem_req_wr  in  1  1 = write, 0 = read.
- mem_wr_data  in  32  write data.
- mem_req_data  out  32  read data; on a write, echoes the written word.
- mem_req_ready  out  1  one-cycle response pulse.
- mem_err  out  1  high together with ready when the address was out of range.
- rd_count  out  16  successful reads, saturating.
- wr_count  out  16  successful writes, saturating.

## Operation
- Storage is an array of DEPTH_WORDS × 32 bits.
  - Word index = addr[log2(DEPTH_WORDS)+1 : 2].
  - Address is in range iff addr < DEPTH_WORDS*4.
  - Contents are not cleared by reset.
- FSM states:
  - IDLE: if mem_req_vaild = 1, latch addr, wr and wr_data, then go to BUSY with cnt = LATENCY-1. If LATENCY = 1, go straight to RESP.
  - BUSY: decrement cnt each cycle. When cnt = 1, the next state is RESP.
  - RESP: drive ready = 1 for one cycle, then go to IDLE unconditionally.
- The access is performed on the edge entering RESP, using only latched values. Inputs that change during BUSY or RESP are ignored.
  - Read, in range: mem_req_data ← array[index].
  - Write, in range: array[index] ← wr_data and mem_req_data ← wr_data.
  - Out of range: no array access, mem_req_data ← 0, mem_err ← 1.
- mem_err is registered and high only in the RESP cycle.
- mem_req_data holds its value between responses.
- Counters increment on the edge entering RESP for in-range accesses only. They stop at 0xFFFF; out-of-range accesses are not counted.
- A write is visible to any subsequent request (read-after-write is coherent).

## Timing
- Reset values:
  - state = IDLE, cnt = 0
  - mem_req_ready = 0, mem_err = 0
  - mem_req_data = 32'h0
  - rd_count = 0, wr_count = 0
- Latency: a request sampled in IDLE in cycle 0 gets ready = 1 in cycle LATENCY, with data and err valid in that same cycle.
- Handshake:
  - The cache must hold valid and its payload until ready. The block never drops a request once accepted.
  - Valid seen in BUSY or RESP is not a new request.
- Back-to-back: the earliest next acceptance is the IDLE cycle LATENCY+1. Minimum spacing between ready pulses is LATENCY+1 cycles.
- Valid still high in the IDLE cycle after RESP is treated as a new request. The cache deasserts valid on the edge where it sees ready.
- Reset mid-operation: an in-flight request is discarded.
  - No array write occurs unless the RESP-entry edge has already passed.
  - No ready is produced.
  - The block accepts requests normally from the first cycle after rst returns high.
- Reset has priority over all other events on the same edge.

## Test plan
- Reset: rst = 0 for 2 cycles while valid = 1 → ready, err and data stay 0, counters = 0, no access counted.
- Read latency: preload word 5 = 32'hDEADBEEF, LATENCY = 4; read addr 32'h14 sampled in cycle 0 → ready high only in cycle 4 with data = 32'hDEADBEEF; rd_count = 1.
- Write then read: write 32'h12345678 to addr 32'h40, then read 32'h40 → the write response echoes 32'h12345678; the read returns 32'h12345678; wr_count = 1, rd_count = 1.
- Payload change during BUSY: accept a read of 32'h14, then switch addr to 32'h18 and wr to 1 in cycle 1 → response is word 5, no write occurs, rd_count increments.
- Out of range: DEPTH_WORDS = 1024, read 32'h1000 → ready with mem_err = 1 and data = 0; the write variant leaves the array unchanged; counters unchanged.
- Reset mid-BUSY: accept a write to 32'h8 (old value 32'hA), assert rst = 0 in cycle 2 → no ready; word 2 is still 32'hA; a fresh read after reset completes in LATENCY cycles.
